// File: rtl/exec_seq_pkg.sv
// -----------------------------------------------------------------------------
// exec_seq_pkg
// Shared definitions for the execute-datapath sequencer. Contains the FSM state
// encoding, which is also visible on the sequencer's state output, and the
// default reset PC and halt instruction constants.
// -----------------------------------------------------------------------------
package exec_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    // syscall encoding: retiring it stops the sequencer
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;

endpackage

// File: rtl/exec_seq_if.sv
// -----------------------------------------------------------------------------
// exec_seq_if
// Instruction-fetch bus between the sequencer (master) and instruction memory
// (slave).
//   imem_req   : master -> slave, fetch request
//   imem_addr  : master -> slave, fetch address
//   imem_ack   : slave -> master, fetch data valid this cycle
//   imem_rdata : slave -> master, fetched instruction word
// -----------------------------------------------------------------------------
interface exec_seq_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/exec_seq_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC computation (mod 2^32).
//   pc          : current PC
//   jump        : jump, takes priority over branch
//   branch      : conditional branch
//   zero        : ALU zero flag, branch condition
//   imm16       : signed branch word offset relative to pc+4
//   instr_index : jump target word index within the pc+4 256 MB region
//   next_pc     : resulting PC
// -----------------------------------------------------------------------------
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    output logic [31:0] next_pc
);

    logic [31:0] p4;
    logic [31:0] br_off;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the final else) so no latch is inferred.
        p4     = pc + 32'd4;
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        if (jump) begin
            next_pc = {p4[31:28], instr_index, 2'b00};
        end else if (branch && zero) begin
            next_pc = p4 + br_off;
        end else begin
            next_pc = p4;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Multi-cycle control sequencer for the execute datapath. Fetches an
// instruction over a req/ack handshake, holds it in the instruction register,
// steps it through DECODE/EXEC/MEM/WB and commits the next PC in WB. The write
// and read strobes are registered so each fires only inside its own state.
//
// Optional feature macro: EXEC_SEQ_PERF_CNT_EN adds cycle_cnt / retired_cnt.
//
// Ports:
//   CLK, RST_N          : clock, synchronous active-low reset
//   imem                : instruction fetch bus (exec_seq_if.master)
//   instr               : instruction register, drives the decoder
//   dec_*               : decoder fields for the held instruction
//   alu_zero            : ALU zero flag (branch condition)
//   mem_ready           : data memory access complete
//   reg_write_en        : register-file write strobe (WB only)
//   mem_write_en        : data-memory write strobe (MEM only)
//   mem_read_en         : data-memory read strobe (MEM only)
//   pc, state, halted   : current PC, FSM state, HALT indicator
//   cycle_cnt           : non-HALT cycle counter (optional)
//   retired_cnt         : WB cycle counter (optional)
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              CLK,
    input  logic              RST_N,
    exec_seq_if.master        imem,
    output logic [31:0]       instr,
    input  logic              dec_branch,
    input  logic              dec_jump,
    input  logic [15:0]       dec_imm16,
    input  logic [25:0]       dec_instr_index,
    input  logic              dec_reg_write,
    input  logic              dec_mem_read,
    input  logic              dec_mem_write,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              reg_write_en,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [31:0]       pc,
    output state_t            state,
    output logic              halted
`ifdef EXEC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`endif
);

    state_t      state_next;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc (
        .pc          (pc),
        .jump        (dec_jump),
        .branch      (dec_branch),
        .zero        (alu_zero),
        .imm16       (dec_imm16),
        .instr_index (dec_instr_index),
        .next_pc     (next_pc)
    );

    // State register
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem.imem_ack) state_next = DECODE;
            DECODE:  state_next = (instr == HALT_INSTR) ? HALT : EXEC;
            EXEC:    state_next = (dec_mem_read || dec_mem_write) ? MEM : WB;
            MEM:     if (mem_ready) state_next = WB;
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        imem.imem_req  = (state == FETCH);
        imem.imem_addr = pc;
        halted         = (state == HALT);
    end

    // Datapath registers. Strobes are loaded from the state being entered, so
    // they are high for exactly the cycles spent in MEM / WB and never depend
    // combinationally on the decoder inputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc           <= RESET_PC;
            instr        <= 32'h0;
            reg_write_en <= 1'b0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
        end else begin
            if (state == FETCH && imem.imem_ack) begin
                instr <= imem.imem_rdata;
            end
            if (state == WB) begin
                pc <= next_pc;
            end
            reg_write_en <= (state_next == WB)  && dec_reg_write;
            mem_write_en <= (state_next == MEM) && dec_mem_write;
            mem_read_en  <= (state_next == MEM) && dec_mem_read;
        end
    end

`ifdef EXEC_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cycle_cnt   <= 32'h0;
            retired_cnt <= 32'h0;
        end else begin
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == WB) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed self-checking bench for exec_sequencer. The bench plays both the
// instruction memory and the decoder/ALU, driving decoder fields directly.
// With EXEC_SEQ_PERF_CNT_EN defined the counter outputs are also checked.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;
    import exec_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] instr;
    logic        dec_branch, dec_jump, dec_reg_write, dec_mem_read, dec_mem_write;
    logic [15:0] dec_imm16;
    logic [25:0] dec_instr_index;
    logic        alu_zero, mem_ready;
    logic        reg_write_en, mem_write_en, mem_read_en;
    logic [31:0] pc;
    state_t      state;
    logic        halted;
`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt, c0, r0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int k, we_hi, re_hi, rw_hi, req_hi, strb_hi;

    exec_seq_if imem_bus ();

    exec_sequencer dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .imem            (imem_bus),
        .instr           (instr),
        .dec_branch      (dec_branch),
        .dec_jump        (dec_jump),
        .dec_imm16       (dec_imm16),
        .dec_instr_index (dec_instr_index),
        .dec_reg_write   (dec_reg_write),
        .dec_mem_read    (dec_mem_read),
        .dec_mem_write   (dec_mem_write),
        .alu_zero        (alu_zero),
        .mem_ready       (mem_ready),
        .reg_write_en    (reg_write_en),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .pc              (pc),
        .state           (state),
        .halted          (halted)
`ifdef EXEC_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt       (cycle_cnt),
        .retired_cnt     (retired_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_dec();
        dec_branch      = 1'b0;
        dec_jump        = 1'b0;
        dec_imm16       = 16'h0;
        dec_instr_index = 26'h0;
        dec_reg_write   = 1'b0;
        dec_mem_read    = 1'b0;
        dec_mem_write   = 1'b0;
        alu_zero        = 1'b0;
        mem_ready       = 1'b0;
    endtask

    // Runs one non-memory instruction from FETCH back to FETCH (4 cycles with
    // a single-cycle fetch). Decoder fields are set by the caller beforehand.
    task automatic run_simple(input string tag, input logic [31:0] word,
                              input logic [31:0] exp_pc, input logic exp_rw);
        check({tag, "_start_fetch"}, state, FETCH);
        imem_bus.imem_rdata = word;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        check({tag, "_decode"}, state, DECODE);
        check({tag, "_instr"}, instr, word);
        tick();
        check({tag, "_exec"}, state, EXEC);
        tick();
        check({tag, "_wb"}, state, WB);
        check({tag, "_wb_rw"}, reg_write_en, exp_rw);
        tick();
        check({tag, "_end_fetch"}, state, FETCH);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_rw_off"}, reg_write_en, 1'b0);
    endtask

    initial begin
        clear_dec();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0022_1820;
        dec_reg_write       = 1'b1;

        // Reset, with ack already high
        repeat (2) tick();
        check("rst_state", state, FETCH);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_rw", reg_write_en, 1'b0);
        check("rst_mw", mem_write_en, 1'b0);
        check("rst_mr", mem_read_en, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_req", imem_bus.imem_req, 1'b1);
        check("rst_addr", imem_bus.imem_addr, 32'h0);

        // ADD r3,r1,r2: FETCH,DECODE,EXEC,WB; ack held high outside FETCH
        RST_N = 1'b1;
        tick();
        check("add_decode", state, DECODE);
        check("add_instr", instr, 32'h0022_1820);
        check("add_req_off", imem_bus.imem_req, 1'b0);
        check("add_rw_dec", reg_write_en, 1'b0);
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("add_exec", state, EXEC);
        check("add_rw_exec", reg_write_en, 1'b0);
        tick();
        check("add_wb", state, WB);
        check("add_rw_wb", reg_write_en, 1'b1);
        check("add_instr_held", instr, 32'h0022_1820);
        imem_bus.imem_ack = 1'b0;
        tick();
        check("add_fetch", state, FETCH);
        check("add_pc", pc, 32'h4);
        check("add_addr", imem_bus.imem_addr, 32'h4);
        check("add_rw_off", reg_write_en, 1'b0);

        // J with branch+zero also high: jump wins (pc 4 -> 0x10, branch would give 0x48)
        clear_dec();
        dec_jump = 1'b1; dec_instr_index = 26'd4;
        dec_branch = 1'b1; alu_zero = 1'b1; dec_imm16 = 16'h0010;
        run_simple("j_wins", 32'h0800_0004, 32'h0000_0010, 1'b0);

        // BEQ imm16=FFFF taken at 0x10 -> 0x10
        clear_dec();
        dec_branch = 1'b1; alu_zero = 1'b1; dec_imm16 = 16'hFFFF;
        run_simple("beq_taken", 32'h1000_FFFF, 32'h0000_0010, 1'b0);

        // Same BEQ not taken -> 0x14
        alu_zero = 1'b0;
        run_simple("beq_not", 32'h1000_FFFF, 32'h0000_0014, 1'b0);

        // J to the top of region 0 -> 0x0FFF_FFFC, then ADD crosses into 0x1000_0000
        clear_dec();
        dec_jump = 1'b1; dec_instr_index = 26'h3FF_FFFF;
        run_simple("j_far", 32'h0BFF_FFFF, 32'h0FFF_FFFC, 1'b0);
        clear_dec();
        dec_reg_write = 1'b1;
        run_simple("add_region", 32'h0022_1820, 32'h1000_0000, 1'b1);

        // J instr_index=0x40 from 0x1000_0000 with branch also taken -> 0x1000_0100
        clear_dec();
        dec_jump = 1'b1; dec_instr_index = 26'h000_0040;
        dec_branch = 1'b1; alu_zero = 1'b1; dec_imm16 = 16'h0001;
        run_simple("j_region", 32'h0800_0040, 32'h1000_0100, 1'b0);

        // SW with mem_ready low for 3 MEM cycles, high on the 4th
        clear_dec();
        dec_mem_write = 1'b1;
        imem_bus.imem_rdata = 32'hAC22_0000;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        tick();
        check("sw_exec", state, EXEC);
        check("sw_mw_exec", mem_write_en, 1'b0);
        tick();
        k = 0; we_hi = 0; re_hi = 0; rw_hi = 0;
        for (int i = 0; i < 10 && state == MEM; i++) begin
            k++;
            if (mem_write_en) we_hi++;
            if (mem_read_en) re_hi++;
            if (reg_write_en) rw_hi++;
            if (k == 4) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        check("sw_mem_dwell", k, 4);
        check("sw_mw_cycles", we_hi, 4);
        check("sw_mr_cycles", re_hi, 0);
        check("sw_rw_in_mem", rw_hi, 0);
        check("sw_wb", state, WB);
        check("sw_mw_wb", mem_write_en, 1'b0);
        check("sw_rw_wb", reg_write_en, 1'b0);
        tick();
        check("sw_fetch", state, FETCH);
        check("sw_pc", pc, 32'h1000_0104);

        // LW with mem_ready already high before MEM: one MEM cycle, then WB writes
        clear_dec();
        dec_mem_read = 1'b1; dec_reg_write = 1'b1;
        imem_bus.imem_rdata = 32'h8C22_0000;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("lw_exec", state, EXEC);
        tick();
        check("lw_mem", state, MEM);
        check("lw_mr", mem_read_en, 1'b1);
        check("lw_mw", mem_write_en, 1'b0);
        tick();
        check("lw_wb", state, WB);
        check("lw_mr_off", mem_read_en, 1'b0);
        check("lw_rw_wb", reg_write_en, 1'b1);
        tick();
        mem_ready = 1'b0;
        check("lw_fetch", state, FETCH);
        check("lw_pc", pc, 32'h1000_0108);

        // SW abandoned by reset mid-MEM
        clear_dec();
        dec_mem_write = 1'b1;
        imem_bus.imem_rdata = 32'hAC22_0000;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        repeat (3) tick();
        check("rstmem_in_mem", state, MEM);
        check("rstmem_mw_on", mem_write_en, 1'b1);
        RST_N = 1'b0;
        tick();
        check("rstmem_state", state, FETCH);
        check("rstmem_pc", pc, 32'h0);
        check("rstmem_mw", mem_write_en, 1'b0);
        check("rstmem_instr", instr, 32'h0);
        RST_N = 1'b1;
        clear_dec();

        // BEQ imm16=FFFE from 0 -> 0xFFFF_FFFC, then ADD wraps to 0
        dec_branch = 1'b1; alu_zero = 1'b1; dec_imm16 = 16'hFFFE;
        run_simple("beq_back", 32'h1000_FFFE, 32'hFFFF_FFFC, 1'b0);
        clear_dec();
        dec_reg_write = 1'b1;
`ifdef EXEC_SEQ_PERF_CNT_EN
        c0 = cycle_cnt;
        r0 = retired_cnt;
`endif
        run_simple("add_wrap", 32'h0022_1820, 32'h0000_0000, 1'b1);
`ifdef EXEC_SEQ_PERF_CNT_EN
        check("perf_cycles", cycle_cnt - c0, 32'd4);
        check("perf_retired", retired_cnt - r0, 32'd1);
`endif

        // HALT: fetch syscall, then nothing moves for 20 cycles
        clear_dec();
        imem_bus.imem_rdata = 32'h0000_000C;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        check("halt_decode", state, DECODE);
        tick();
        check("halt_state", state, HALT);
        check("halt_flag", halted, 1'b1);
        check("halt_req", imem_bus.imem_req, 1'b0);
`ifdef EXEC_SEQ_PERF_CNT_EN
        c0 = cycle_cnt;
`endif
        dec_reg_write = 1'b1; dec_mem_write = 1'b1; dec_mem_read = 1'b1;
        mem_ready = 1'b1; dec_jump = 1'b1;
        req_hi = 0; strb_hi = 0;
        for (int i = 0; i < 20; i++) begin
            imem_bus.imem_ack   = i[0];
            imem_bus.imem_rdata = 32'h0022_1820;
            tick();
            if (imem_bus.imem_req) req_hi++;
            if (reg_write_en || mem_write_en || mem_read_en) strb_hi++;
        end
        check("halt_req_cycles", req_hi, 0);
        check("halt_strobe_cycles", strb_hi, 0);
        check("halt_stays", state, HALT);
        check("halt_pc_frozen", pc, 32'h0);
        check("halt_instr_held", instr, 32'h0000_000C);
`ifdef EXEC_SEQ_PERF_CNT_EN
        check("perf_halt_frozen", cycle_cnt, c0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle control sequencer for the execute datapath: instruction register, decoder, register file, ALU and data memory.
- Fetches an instruction over a req/ack handshake and holds it stable for the datapath.
- Steps the instruction through DECODE/EXEC/MEM/WB and gates the register-file and data-memory write strobes so each fires exactly once per instruction.
- Computes and commits the next PC from the decoder's branch/jump/imm16/instr_index and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_INSTR, 32'h0000_000C, instruction word (syscall) that stops sequencing

Ports:
CLK  in  1  single clock, all state updates on rising edge
RST_N  in  1  reset, synchronous, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register, drives the decoder
dec_branch  in  1  decoder: conditional branch
dec_jump  in  1  decoder: jump
dec_imm16  in  16  decoder: branch offset
dec_instr_index  in  26  decoder: jump target index
dec_reg_write  in  1  decoder: instruction writes rw
dec_mem_read  in  1  decoder: load
dec_mem_write  in  1  decoder: store
alu_zero  in  1  ALU zero flag
mem_ready  in  1  data memory access complete
reg_write_en  out  1  gated register-file write strobe
mem_write_en  out  1  gated data-memory write strobe
mem_read_en  out  1  gated data-memory read strobe
pc  out  32  current PC
state  out  3  current FSM state
halted  out  1  high in HALT

Behaviour:
- Reset: RST_N low at a rising edge sets state=FETCH, pc=RESET_PC, instr=0. Strobes reg_write_en, mem_write_en and mem_read_en are all 0; halted=0. This applies in any state, including mid-MEM; a pending store is abandoned.
- All outputs are registered or decoded from state only, with no combinational path from inputs. imem_addr=pc.
- FETCH:
  - imem_req=1.
  - On a cycle with imem_ack=1: instr<=imem_rdata, then DECODE.
  - Otherwise stay in FETCH, with no timeout.
  - Minimum one cycle.
- DECODE (1 cycle):
  - instr==HALT_INSTR -> HALT.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - dec_mem_read|dec_mem_write -> MEM.
  - Otherwise -> WB.
- MEM:
  - mem_read_en=dec_mem_read; mem_write_en=dec_mem_write.
  - Stay until mem_ready=1, then WB.
  - mem_ready in the first MEM cycle is accepted.
- WB (1 cycle):
  - reg_write_en=dec_reg_write.
  - pc<=next_pc.
  - -> FETCH.
- HALT: absorbing. All strobes 0, imem_req=0, halted=1, pc frozen. Only reset exits.
- next_pc (mod 2^32, evaluated in WB):
  - p4 = pc+4.
  - If dec_jump: next_pc={p4[31:28], dec_instr_index, 2'b00}. Jump has priority over branch.
  - Else if dec_branch&alu_zero: next_pc = p4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - Else next_pc = p4.
- Wrap-around: pc=32'hFFFF_FFFC with sequential flow gives next_pc=0.
- Ignored inputs: imem_ack outside FETCH and mem_ready outside MEM have no effect.
- Strobe width: each strobe is high for at most the cycles of its state, so exactly one register write per instruction.
- Latency, non-memory instruction: FETCH(n≥1) + DECODE + EXEC + WB = n+3 cycles.
- Latency, memory instruction: n+3+m cycles, where m≥1 is the MEM dwell.

Optional Feature:
EXEC_SEQ_PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and retired_cnt[31:0].
  - Both reset to 0.
  - cycle_cnt increments every cycle while not in HALT.
  - retired_cnt increments on each WB cycle.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package exec_seq_pkg:
  - state encoding FETCH=3'd0, DECODE=3'd1, EXEC=3'd2, MEM=3'd3, WB=3'd4, HALT=3'd5
  - default HALT_INSTR constant
- Sub-module next_pc_calc: combinational, inputs pc, jump, branch, zero, imm16, instr_index; output next_pc. It is unit-testable in isolation.

Test Plan:
- Reset with imem_ack=1 and imem_rdata=ADD r3,r1,r2 (0x00221820) -> sequence FETCH,DECODE,EXEC,WB. reg_write_en high only in WB; pc 0->4; total 4 cycles.
- BEQ with imm16=16'hFFFF, alu_zero=1, pc=0x10 -> pc=0x10. Repeat with alu_zero=0 -> pc=0x14.
- J with instr_index=26'h0000040, pc=0x1000_0000 -> pc=0x1000_0100. With dec_branch and alu_zero also high, the jump wins.
- SW with mem_ready held low 3 cycles -> mem_write_en high exactly 4 cycles, reg_write_en=0, then FETCH. Assert RST_N low during MEM in a second run -> next cycle state=FETCH, pc=RESET_PC, mem_write_en=0.
- Fetch 0x0000000C -> HALT, halted=1. imem_req stays 0 for 20 cycles despite imem_ack toggling.
- pc=32'hFFFF_FFFC executing ADD -> pc wraps to 0. With EXEC_SEQ_PERF_CNT_EN defined, retired_cnt=1 and cycle_cnt=4.
